sd_spi_byte_phy: RTL and testbench
==================================

Name: sd_spi_byte_phy

Overview:
- SPI-mode physical layer for the SD card. It sits directly downstream of the SD init/command controller and drives the card pins.
- The controller hands it one byte at a time over a valid/ready handshake. The block shifts each byte out MSB-first on sd_cmd, captures 8 bits from sd_data0, and returns the received byte.
- It also produces the power-up dummy clocks (CS high, MOSI high), owns the 400 kHz / 25 MHz clock selection, and gates chip-select changes so they only occur between bytes.

Parameters:
- HALF_SLOW, 125: clk cycles per sd_cclk half-period in slow mode (100 MHz -> 400 kHz).
- HALF_FAST, 2: clk cycles per sd_cclk half-period in fast mode (100 MHz -> 25 MHz).
- INIT_CYCLES, 80: sd_cclk pulses issued per init request (at least 74 per SD spec).

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  synchronous active-low reset
- fast_sel  in  1  1 = use HALF_FAST, 0 = use HALF_SLOW
- cs_req  in  1  1 = select card (drive sd_cs low)
- init_req  in  1  pulse: issue INIT_CYCLES dummy clocks
- init_done  out  1  one-cycle pulse when dummy clocks finish
- tx_valid  in  1  byte offered
- tx_ready  out  1  block can accept a byte
- tx_data  in  8  byte to send, MSB first
- rx_valid  out  1  one-cycle pulse, rx_data valid
- rx_data  out  8  byte captured from sd_data0
- busy  out  1  state != IDLE
- sd_cclk  out  1  SPI clock, idle low (mode 0)
- sd_cmd  out  1  MOSI, idle high
- sd_data0  in  1  MISO
- sd_cs  out  1  chip select, active low

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, sd_cclk=0, sd_cmd=1, sd_cs=1, tx_ready=0 during reset, rx_valid=0, init_done=0, rx_data=0, all counters 0.
- Reset asserted mid-byte or mid-init aborts immediately. No rx_valid or init_done pulse is produced; pins return to reset values on the next edge.
- States: IDLE, INIT, SHIFT.
- IDLE:
  - tx_ready=1 only when in IDLE, not in reset, and init_req=0.
  - sd_cs <= ~cs_req, updated in IDLE only. A cs_req change during INIT or SHIFT takes effect on the first IDLE cycle.
  - init_req=1 -> INIT. init_req has priority over tx_valid; tx_ready is low in that cycle.
  - tx_valid && tx_ready -> latch tx_data into the shift register and set sd_cmd <= tx_data[7]. Latch half = fast_sel ? HALF_FAST : HALF_SLOW. Enter SHIFT.
- Clock generation:
  - Half-period counter counts 0..half-1. On wrap, sd_cclk toggles.
  - half is latched at byte/init start; fast_sel changes mid-transfer are ignored.
- SHIFT (SPI mode 0):
  - On each sd_cclk rising toggle, shift sd_data0 into the receive register (MSB first).
  - On each falling toggle, present the next tx bit on sd_cmd.
  - After the 8th falling toggle: sd_cmd <= 1 and sd_cclk=0. The next cycle pulses rx_valid=1 with rx_data, then returns to IDLE.
  - Latency from the accept cycle to the rx_valid cycle = 16*half + 1 clk cycles; tx_ready goes high in the same cycle as rx_valid.
  - Back-to-back bytes: the earliest next accept is the cycle of rx_valid.
- INIT:
  - Forces sd_cs=1 and sd_cmd=1, and always uses HALF_SLOW regardless of fast_sel.
  - Emits exactly INIT_CYCLES full sd_cclk pulses, ending low.
  - Then pulses init_done for 1 cycle -> IDLE.
  - init_req during INIT is ignored; tx_valid during INIT is not accepted.
- Width rules:
  - Half counter is wide enough for HALF_SLOW-1.
  - Bit counter is 4 bits; init counter is wide enough for 2*INIT_CYCLES.

Optional Feature:
- Macro SD_SPI_CRC16_EN.
- When defined, adds:
  - input crc_clear (1 bit): synchronous clear to 0x0000.
  - output rx_crc16 (16 bits): CRC-16-CCITT (x^16+x^12+x^5+1, init 0), updated bit-serially at each SHIFT rising-edge sample.
  - crc_clear coincident with a sample: clear wins, and that bit is dropped.
  - rx_crc16 resets to 0.
- When undefined: no CRC ports or logic.

Test Plan:
- Reset values: hold rst_n=0 for 5 cycles -> sd_cclk=0, sd_cmd=1, sd_cs=1, rx_valid=0, busy=0. After release, tx_ready=1.
- Slow byte, loopback: sd_data0 tied to sd_cmd, fast_sel=0, cs_req=1, send 0xA5.
  - rx_valid exactly 2001 cycles after accept, with rx_data=0xA5.
  - 8 rising edges observed; sd_cs=0 throughout.
- Fast byte and back-to-back: fast_sel=1, send 0x3C then 0xC3 with tx_valid held.
  - rx_valid at +33 and +66, values 0x3C and 0xC3.
  - fast_sel toggled mid-byte has no effect on timing.
- Init: init_req pulse with cs_req=1, fast_sel=1, and tx_valid=1 in the same cycle.
  - Exactly 80 sd_cclk rising edges at 400 kHz.
  - sd_cs=1 and sd_cmd=1 throughout; init_done at +20001.
  - Byte not accepted until after init_done.
- Reset mid-byte: send 0xFF, assert rst_n=0 after 500 cycles.
  - No rx_valid; pins return to reset values on the next edge.
  - A subsequent byte transfers correctly.
- CRC (SD_SPI_CRC16_EN): crc_clear, then receive 512 bytes with sd_data0=1 -> rx_crc16=0x7FA1.

Source files
------------

// File: rtl/sd_spi_byte_phy.sv
// SD card SPI-mode byte PHY: mode-0 byte shifter, power-up dummy clocks, cclk divider and CS gating.
// Optional receive CRC-16-CCITT is compiled in when SD_SPI_CRC16_EN is defined.
module sd_spi_byte_phy #(
    parameter int HALF_SLOW   = 125,
    parameter int HALF_FAST   = 2,
    parameter int INIT_CYCLES = 80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fast_sel,
    input  logic       cs_req,
    input  logic       init_req,
    output logic       init_done,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       sd_cclk,
    output logic       sd_cmd,
    input  logic       sd_data0,
    output logic       sd_cs
`ifdef SD_SPI_CRC16_EN
    ,
    input  logic        crc_clear,
    output logic [15:0] rx_crc16
`endif
);

    localparam int HW = (HALF_SLOW > 1) ? $clog2(HALF_SLOW) : 1;
    localparam int IW = $clog2(2 * INIT_CYCLES + 1);
    localparam logic [HW-1:0] SLOW_M1   = HW'(HALF_SLOW - 1);
    localparam logic [HW-1:0] FAST_M1   = HW'(HALF_FAST - 1);
    localparam logic [IW-1:0] INIT_LAST = IW'(2 * INIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   half_q, half_d;
    logic [HW-1:0]   cnt_q, cnt_d;
    logic            cclk_q, cclk_d;
    logic            cmd_q, cmd_d;
    logic            cs_q, cs_d;
    logic [6:0]      tx_sh_q, tx_sh_d;
    logic [7:0]      rx_sh_q, rx_sh_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            init_done_q, init_done_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]   init_cnt_q, init_cnt_d;
    logic            wrap;
    logic            sample;

`ifdef SD_SPI_CRC16_EN
    logic [15:0]     crc_q, crc_d;
    logic            crc_fb;
`endif

    assign tx_ready  = (state_q == ST_IDLE) && rst_n && !init_req;
    assign busy      = (state_q != ST_IDLE);
    assign sd_cclk   = cclk_q;
    assign sd_cmd    = cmd_q;
    assign sd_cs     = cs_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign init_done = init_done_q;

    assign wrap   = (cnt_q == half_q);
    // A rising cclk toggle in SHIFT is the mode-0 sample point for MISO.
    assign sample = (state_q == ST_SHIFT) && wrap && !cclk_q;

    always_comb begin
        state_d     = state_q;
        half_d      = half_q;
        cnt_d       = cnt_q;
        cclk_d      = cclk_q;
        cmd_d       = cmd_q;
        cs_d        = cs_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        init_done_d = 1'b0;
        bit_cnt_d   = bit_cnt_q;
        init_cnt_d  = init_cnt_q;

        case (state_q)
            ST_IDLE: begin
                cs_d  = ~cs_req;
                cnt_d = '0;
                if (init_req) begin
                    state_d    = ST_INIT;
                    half_d     = SLOW_M1;
                    init_cnt_d = '0;
                    cs_d       = 1'b1;
                    cmd_d      = 1'b1;
                    cclk_d     = 1'b0;
                end else if (tx_valid) begin
                    state_d   = ST_SHIFT;
                    half_d    = fast_sel ? FAST_M1 : SLOW_M1;
                    tx_sh_d   = tx_data[6:0];
                    cmd_d     = tx_data[7];
                    bit_cnt_d = '0;
                end
            end

            ST_INIT: begin
                if (wrap) begin
                    cnt_d  = '0;
                    cclk_d = ~cclk_q;
                    if (init_cnt_q == INIT_LAST) begin
                        state_d     = ST_IDLE;
                        cclk_d      = 1'b0;
                        init_cnt_d  = '0;
                        init_done_d = 1'b1;
                    end else begin
                        init_cnt_d = init_cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_SHIFT: begin
                if (wrap) begin
                    cnt_d  = '0;
                    cclk_d = ~cclk_q;
                    if (!cclk_q) begin
                        rx_sh_d = {rx_sh_q[6:0], sd_data0};
                    end else if (bit_cnt_q == 4'd7) begin
                        // Eighth falling toggle: byte complete, MOSI back to idle-high.
                        state_d    = ST_IDLE;
                        cmd_d      = 1'b1;
                        bit_cnt_d  = '0;
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_sh_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        cmd_d     = tx_sh_q[6];
                        tx_sh_d   = {tx_sh_q[5:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef SD_SPI_CRC16_EN
    assign crc_fb   = crc_q[15] ^ sd_data0;
    assign rx_crc16 = crc_q;

    always_comb begin
        crc_d = crc_q;
        if (crc_clear) begin
            crc_d = 16'h0000;
        end else if (sample) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_q <= 16'h0000;
        end else begin
            crc_q <= crc_d;
        end
    end
`else
    logic unused_sample;
    assign unused_sample = sample;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            half_q      <= '0;
            cnt_q       <= '0;
            cclk_q      <= 1'b0;
            cmd_q       <= 1'b1;
            cs_q        <= 1'b1;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            init_done_q <= 1'b0;
            bit_cnt_q   <= '0;
            init_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            half_q      <= half_d;
            cnt_q       <= cnt_d;
            cclk_q      <= cclk_d;
            cmd_q       <= cmd_d;
            cs_q        <= cs_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            init_done_q <= init_done_d;
            bit_cnt_q   <= bit_cnt_d;
            init_cnt_q  <= init_cnt_d;
        end
    end

endmodule

// File: tb/tb_sd_spi_byte_phy.sv
// Directed bench for sd_spi_byte_phy: table of single-byte transfers plus reset, back-to-back, init and CRC sequences.
`timescale 1ns/1ps
module tb_sd_spi_byte_phy;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fast_sel;
    logic       cs_req;
    logic       init_req;
    logic       init_done;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       sd_cclk;
    logic       sd_cmd;
    logic       sd_data0;
    logic       sd_cs;
    logic [1:0] miso_mode;   // 0 loopback, 1 inverted loopback, 2 constant 0, 3 constant 1
`ifdef SD_SPI_CRC16_EN
    logic        crc_clear;
    logic [15:0] rx_crc16;
`endif

    int n_checks = 0;
    int n_errors = 0;

    assign sd_data0 = (miso_mode == 2'd0) ? sd_cmd :
                      (miso_mode == 2'd1) ? ~sd_cmd :
                      (miso_mode == 2'd3);

    always #5 clk = ~clk;

    sd_spi_byte_phy dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fast_sel  (fast_sel),
        .cs_req    (cs_req),
        .init_req  (init_req),
        .init_done (init_done),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .busy      (busy),
        .sd_cclk   (sd_cclk),
        .sd_cmd    (sd_cmd),
        .sd_data0  (sd_data0),
        .sd_cs     (sd_cs)
`ifdef SD_SPI_CRC16_EN
        ,
        .crc_clear (crc_clear),
        .rx_crc16  (rx_crc16)
`endif
    );

    typedef struct {
        logic [7:0] tx;
        logic       fast;
        logic [1:0] mode;
        logic [7:0] exp_rx;
        int         exp_lat;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte in the current cycle and follow it to rx_valid.
    task automatic run_byte(input logic [7:0] tx, input logic [7:0] exp_rx,
                            input int exp_lat, input string nm);
        int   lat;
        int   rises;
        logic prev;
        logic cs_bad;
        check({nm, " tx_ready"}, 32'(tx_ready), 32'd1);
        tx_data  = tx;
        tx_valid = 1'b1;
        lat      = 0;
        rises    = 0;
        prev     = sd_cclk;
        cs_bad   = 1'b0;
        while (lat < 5000) begin
            step();
            lat++;
            tx_valid = 1'b0;
            if (sd_cclk && !prev) rises++;
            prev = sd_cclk;
            if (sd_cs !== 1'b0) cs_bad = 1'b1;
            if (rx_valid === 1'b1) break;
        end
        check({nm, " latency"}, 32'(lat), 32'(exp_lat));
        check({nm, " rx_data"}, 32'(rx_data), 32'(exp_rx));
        check({nm, " rises"}, 32'(rises), 32'd8);
        check({nm, " cs_low"}, 32'(cs_bad), 32'd0);
        $display("byte %s: tx=0x%02h rx=0x%02h latency=%0d rises=%0d", nm, tx, rx_data, lat, rises);
    endtask

    initial begin
        int   lat;
        int   rises;
        int   last_rise;
        logic prev;
        logic bad;
        logic spacing_bad;
        logic rdy_bad;
        logic [7:0] r1;

        vecs[0] = '{tx: 8'hA5, fast: 1'b0, mode: 2'd0, exp_rx: 8'hA5, exp_lat: 2001};
        vecs[1] = '{tx: 8'h3C, fast: 1'b1, mode: 2'd0, exp_rx: 8'h3C, exp_lat: 33};
        vecs[2] = '{tx: 8'hA5, fast: 1'b1, mode: 2'd1, exp_rx: 8'h5A, exp_lat: 33};
        vecs[3] = '{tx: 8'h00, fast: 1'b1, mode: 2'd3, exp_rx: 8'hFF, exp_lat: 33};
        vecs[4] = '{tx: 8'hFF, fast: 1'b1, mode: 2'd2, exp_rx: 8'h00, exp_lat: 33};
        vecs[5] = '{tx: 8'h81, fast: 1'b0, mode: 2'd1, exp_rx: 8'h7E, exp_lat: 2001};

        rst_n     = 1'b0;
        fast_sel  = 1'b0;
        cs_req    = 1'b0;
        init_req  = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        miso_mode = 2'd0;
`ifdef SD_SPI_CRC16_EN
        crc_clear = 1'b0;
`endif

        // Reset values
        repeat (5) step();
        check("reset sd_cclk", 32'(sd_cclk), 32'd0);
        check("reset sd_cmd", 32'(sd_cmd), 32'd1);
        check("reset sd_cs", 32'(sd_cs), 32'd1);
        check("reset rx_valid", 32'(rx_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset tx_ready", 32'(tx_ready), 32'd0);
        check("reset rx_data", 32'(rx_data), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post-reset tx_ready", 32'(tx_ready), 32'd1);
        $display("reset: cclk=%0b cmd=%0b cs=%0b tx_ready=%0b", sd_cclk, sd_cmd, sd_cs, tx_ready);

        // Table of single-byte transfers
        cs_req = 1'b1;
        step();
        step();
        for (int i = 0; i < 6; i++) begin
            fast_sel  = vecs[i].fast;
            miso_mode = vecs[i].mode;
            run_byte(vecs[i].tx, vecs[i].exp_rx, vecs[i].exp_lat, $sformatf("vec%0d", i));
            step();
            check($sformatf("vec%0d rx_valid pulse", i), 32'(rx_valid), 32'd0);
            check($sformatf("vec%0d idle cmd", i), 32'(sd_cmd), 32'd1);
        end

        // Back-to-back fast bytes with tx_valid held; fast_sel wiggled mid-byte
        fast_sel  = 1'b1;
        miso_mode = 2'd0;
        tx_data   = 8'h3C;
        tx_valid  = 1'b1;
        lat       = 0;
        r1        = 8'h00;
        bad       = 1'b0;
        while (lat < 200) begin
            step();
            lat++;
            if (lat == 1) tx_data = 8'hC3;
            if (lat == 10 || lat == 45) fast_sel = 1'b0;
            if (lat == 20 || lat == 55) fast_sel = 1'b1;
            if (lat == 34) tx_valid = 1'b0;
            if (rx_valid === 1'b1) begin
                if (lat == 33) r1 = rx_data;
                else if (lat == 66) break;
                else bad = 1'b1;
            end
        end
        tx_valid = 1'b0;
        check("b2b first rx_data", 32'(r1), 32'h3C);
        check("b2b second latency", 32'(lat), 32'd66);
        check("b2b second rx_data", 32'(rx_data), 32'hC3);
        check("b2b stray rx_valid", 32'(bad), 32'd0);
        $display("b2b: first=0x%02h second=0x%02h at +%0d", r1, rx_data, lat);
        step();

        // Init with tx_valid competing in the request cycle
        fast_sel    = 1'b1;
        cs_req      = 1'b1;
        init_req    = 1'b1;
        tx_valid    = 1'b1;
        tx_data     = 8'h5A;
        #1;
        check("init priority tx_ready", 32'(tx_ready), 32'd0);
        lat         = 0;
        rises       = 0;
        last_rise   = 0;
        prev        = sd_cclk;
        bad         = 1'b0;
        spacing_bad = 1'b0;
        rdy_bad     = 1'b0;
        while (lat < 25000) begin
            step();
            lat++;
            init_req = 1'b0;
            if (init_done === 1'b1) break;
            if (sd_cclk && !prev) begin
                if (rises > 0 && (lat - last_rise) != 250) spacing_bad = 1'b1;
                rises++;
                last_rise = lat;
            end
            prev = sd_cclk;
            if (sd_cs !== 1'b1 || sd_cmd !== 1'b1 || rx_valid !== 1'b0) bad = 1'b1;
            if (tx_ready !== 1'b0 || busy !== 1'b1) rdy_bad = 1'b1;
        end
        check("init done latency", 32'(lat), 32'd20001);
        check("init rises", 32'(rises), 32'd80);
        check("init rise spacing", 32'(spacing_bad), 32'd0);
        check("init pins", 32'(bad), 32'd0);
        check("init no accept", 32'(rdy_bad), 32'd0);
        check("init end cclk", 32'(sd_cclk), 32'd0);
        $display("init: done at +%0d rises=%0d", lat, rises);
        // The held byte is taken in the init_done cycle
        run_byte(8'h5A, 8'h5A, 33, "post-init");
        step();
        check("post-init init_done pulse", 32'(init_done), 32'd0);

        // Reset mid-byte
        fast_sel  = 1'b0;
        miso_mode = 2'd0;
        tx_data   = 8'hFF;
        tx_valid  = 1'b1;
        step();
        tx_valid  = 1'b0;
        repeat (499) step();
        check("midbyte busy before reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        step();
        check("midbyte reset cclk", 32'(sd_cclk), 32'd0);
        check("midbyte reset cmd", 32'(sd_cmd), 32'd1);
        check("midbyte reset cs", 32'(sd_cs), 32'd1);
        check("midbyte reset busy", 32'(busy), 32'd0);
        bad = 1'b0;
        repeat (3) begin
            step();
            if (rx_valid !== 1'b0 || init_done !== 1'b0) bad = 1'b1;
        end
        rst_n = 1'b1;
        repeat (3000) begin
            step();
            if (rx_valid !== 1'b0) bad = 1'b1;
        end
        check("midbyte no rx_valid", 32'(bad), 32'd0);
        $display("midbyte reset: cclk=%0b cmd=%0b cs=%0b", sd_cclk, sd_cmd, sd_cs);
        fast_sel = 1'b1;
        run_byte(8'h96, 8'h96, 33, "after-reset");

`ifdef SD_SPI_CRC16_EN
        // 512-byte all-ones block into the CRC
        step();
        crc_clear = 1'b1;
        step();
        crc_clear = 1'b0;
        check("crc clear", 32'(rx_crc16), 32'h0);
        miso_mode = 2'd3;
        tx_data   = 8'hFF;
        tx_valid  = 1'b1;
        rises     = 0;
        lat       = 0;
        while (lat < 20000 && rises < 512) begin
            step();
            lat++;
            if (rx_valid === 1'b1) rises++;
            tx_valid = (rises < 512);
        end
        tx_valid = 1'b0;
        check("crc block bytes", 32'(rises), 32'd512);
        check("crc16 value", 32'(rx_crc16), 32'h7FA1);
        $display("crc: bytes=%0d crc=0x%04h", rises, rx_crc16);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
